gol_grid_serializer: RTL

GOL_GRID_SERIALIZER -- requirements
Module: gol_grid_serializer

---
 rtl/gol_grid_serializer_if.sv | 45 ++++
 rtl/gol_grid_serializer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/gol_grid_serializer_if.sv
// ============================================================================
// gol_grid_serializer_if
// Row stream carrying one grid row per valid/ready transfer.
// row_parity exists only when GOL_SER_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface gol_grid_serializer_if #(
  parameter int ROW_W = 8,
  parameter int IDX_W = 3
);
  logic [ROW_W-1:0] row_data;
  logic [IDX_W-1:0] row_idx;
  logic             row_valid;
  logic             row_ready;
  logic             row_last;
`ifdef GOL_SER_PARITY_EN
  logic             row_parity;
`endif

  modport master (
    output row_data,
    output row_idx,
    output row_valid,
    output row_last,
`ifdef GOL_SER_PARITY_EN
    output row_parity,
`endif
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_idx,
    input  row_valid,
    input  row_last,
`ifdef GOL_SER_PARITY_EN
    input  row_parity,
`endif
    output row_ready
  );
endinterface

`default_nettype wire

// File: rtl/gol_grid_serializer.sv
// ============================================================================
// gol_grid_serializer
// Captures a Game-of-Life grid into a shadow register on load and streams it
// out one row per valid/ready transfer, row 0 being the MSB row. Counts
// completed frames in a wrapping 16-bit generation counter.
// Optional feature macro: GOL_SER_PARITY_EN (adds row.row_parity).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gol_grid_serializer #(
  parameter  int NUM_ROWS = 8,
  parameter  int ROW_W    = 8,
  localparam int IDX_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int GRID_W   = NUM_ROWS * ROW_W
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [GRID_W-1:0] grid_in,
  input  wire logic              load,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            gen_count,
  gol_grid_serializer_if.master  row
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_ROWS - 1);

  state_t            r_state;
  logic [GRID_W-1:0] r_shadow;
  logic [ROW_W-1:0]  r_row_data;
  logic [IDX_W-1:0]  r_idx;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_gen_count;

  logic [ROW_W-1:0]  w_rows [NUM_ROWS];
  logic [IDX_W-1:0]  w_next_idx;
  logic [ROW_W-1:0]  w_next_row;
  logic              w_next_last;

  // Row view of the shadow register: row r sits at the r-th slice from the top.
  generate
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_rows
      assign w_rows[r] = r_shadow[(NUM_ROWS - r) * ROW_W - 1 -: ROW_W];
    end
  endgenerate

  assign w_next_idx  = r_idx + IDX_W'(1);
  assign w_next_row  = w_rows[w_next_idx];
  assign w_next_last = (w_next_idx == c_last_idx);

  // Frame sequencer: IDLE waits for load, SEND streams rows, DONE pulses once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_row_data  <= '0;
      r_idx       <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_gen_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            // Row 0 is presented straight from grid_in so it is valid next cycle.
            r_shadow   <= grid_in;
            r_row_data <= grid_in[GRID_W-1 -: ROW_W];
            r_idx      <= '0;
            r_last     <= (NUM_ROWS == 1);
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (row.row_ready) begin
            if (r_last) begin
              r_valid     <= 1'b0;
              r_last      <= 1'b0;
              r_done      <= 1'b1;
              r_gen_count <= r_gen_count + 16'd1;
              r_state     <= DONE;
            end else begin
              r_idx      <= w_next_idx;
              r_row_data <= w_next_row;
              r_last     <= w_next_last;
            end
          end
        end
        DONE: begin
          // Any load seen here is dropped; the sink must wait for IDLE.
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign frame_done    = r_done;
  assign gen_count     = r_gen_count;
  assign row.row_data  = r_row_data;
  assign row.row_idx   = r_idx;
  assign row.row_valid = r_valid;
  assign row.row_last  = r_last;

`ifdef GOL_SER_PARITY_EN
  // Parity is forced low whenever no row is being offered.
  assign row.row_parity = r_valid & (^r_row_data);
`endif

endmodule

`default_nettype wire
